// File: rtl/commit_trace_fifo_pkg.sv
// Shared record layout and helpers for the commit trace FIFO.
// The record type is used by the RTL and by the simulation bench.
package commit_trace_fifo_pkg;

  localparam int seq_w   = 64;
  localparam int pc_w    = 64;
  localparam int ir_w    = 32;
  localparam int gpra_w  = 6;
  localparam int gprv_w  = 64;
  localparam int drops_w = 64;

  typedef struct packed {
    logic [seq_w-1:0]  seq;
    logic              lost;
    logic [pc_w-1:0]   pc;
    logic [ir_w-1:0]   ir;
    logic              gprw;
    logic [gpra_w-1:0] gpra;
    logic [gprv_w-1:0] gprv;
  } cmt_rec_t;

  // Adds without wrapping; pins at all-ones once the sum overflows.
  function automatic logic [drops_w-1:0] sat_add(input logic [drops_w-1:0] a,
                                                 input logic [drops_w-1:0] b);
    logic [drops_w:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[drops_w] ? {drops_w{1'b1}} : sum[drops_w-1:0];
  endfunction

endpackage

// File: rtl/commit_trace_fifo_compact.sv
// Lane compaction: each valid lane gets the number of valid lanes below it,
// which is its slot offset from the write pointer.
module cmt_compact #(
  parameter int lanes = 4,
  localparam int cnt_w = $clog2(lanes + 1)
) (
  input  logic [lanes-1:0]            vld,
  output logic [lanes-1:0][cnt_w-1:0] offset,
  output logic [cnt_w-1:0]            count
);
  import commit_trace_fifo_pkg::*;

  logic [cnt_w-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < lanes; i++) begin
      offset[i] = acc;
      acc       = acc + cnt_w'(vld[i]);
    end
    count = acc;
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// Multi-lane commit trace buffer: compacts a batch of committed instructions
// into a circular record store and drains them one per handshake.
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int lanes     = 4,
  parameter int depth     = 32,
  parameter int drop_mode = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [lanes-1:0]              cmt_vld,
  input  logic [lanes-1:0][pc_w-1:0]    cmt_pc,
  input  logic [lanes-1:0][ir_w-1:0]    cmt_ir,
  input  logic [lanes-1:0]              cmt_gprw,
  input  logic [lanes-1:0][gpra_w-1:0]  cmt_gpra,
  input  logic [lanes-1:0][gprv_w-1:0]  cmt_gprv,
  output logic                          in_stall,
  output logic                          out_valid,
  input  logic                          out_ready,
  output cmt_rec_t                      out_rec,
  output logic [$clog2(depth):0]        level,
  output logic [drops_w-1:0]            drops
);

  localparam int aw    = $clog2(depth);
  localparam int lw    = aw + 1;
  localparam int cnt_w = $clog2(lanes + 1);

  cmt_rec_t mem [depth];

  logic [aw-1:0]              wr_ptr;
  logic [aw-1:0]              rd_ptr;
  logic [seq_w-1:0]           seq;
  logic                       lost;
  logic [lanes-1:0][cnt_w-1:0] offset;
  logic [cnt_w-1:0]           n;
  logic [lw-1:0]              n_ext;
  logic [lw-1:0]              free;
  logic                       has_batch;
  logic                       accept;
  logic                       overflow;
  logic                       drop;
  logic                       pop;
  logic [aw-1:0]              slot [lanes];
  cmt_rec_t                   rec  [lanes];

  cmt_compact #(.lanes(lanes)) u_compact (
    .vld    (cmt_vld),
    .offset (offset),
    .count  (n)
  );

  // Space is judged on the registered level only; a pop this cycle is not credited.
  assign n_ext     = lw'(n);
  assign free      = lw'(depth) - level;
  assign has_batch = (n != '0);
  assign accept    = has_batch && (n_ext <= free);
  assign overflow  = has_batch && (n_ext > free);
  assign in_stall  = (drop_mode == 0) ? overflow : 1'b0;
  assign drop      = (drop_mode != 0) && overflow;

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign out_rec   = mem[rd_ptr];

  // The lost marker lands only on the first record of the batch after a drop.
  always_comb begin
    for (int i = 0; i < lanes; i++) begin
      slot[i]     = wr_ptr + aw'(offset[i]);
      rec[i].seq  = seq + seq_w'(offset[i]);
      rec[i].lost = lost && (offset[i] == '0);
      rec[i].pc   = cmt_pc[i];
      rec[i].ir   = cmt_ir[i];
      rec[i].gprw = cmt_gprw[i];
      rec[i].gpra = cmt_gpra[i];
      rec[i].gprv = cmt_gprv[i];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < lanes; i++) begin
        if (cmt_vld[i]) begin
          mem[slot[i]] <= rec[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      seq    <= '0;
      drops  <= '0;
      lost   <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + aw'(n);
        seq    <= seq + seq_w'(n);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + aw'(1);
      end
      level <= level + (accept ? n_ext : lw'(0)) - (pop ? lw'(1) : lw'(0));
      if (drop) begin
        drops <= sat_add(drops, drops_w'(n));
        lost  <= 1'b1;
      end else if (accept) begin
        lost  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!accept || (level + n_ext <= lw'(depth)))
        else $error("commit_trace_fifo overflow");
      assert (!pop || (level != '0))
        else $error("commit_trace_fifo underflow");
    end
  end

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 SHALL have parameter lanes, default 4: commit lanes sampled per cycle (1..8).
REQ-002 SHALL have parameter depth, default 32: record slots, power of two, >= lanes.
REQ-003 SHALL have parameter drop_mode, default 0: 0 = backpressure core, 1 = drop and count.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmt_vld  input  [lanes]  lane i commits a record this cycle.
REQ-007 SHALL have port cmt_pc / cmt_ir  input  [lanes]x64 / [lanes]x32  committed PC / instruction.
REQ-008 SHALL have port cmt_gprw / cmt_gpra / cmt_gprv  input  [lanes]x1 / x6 / x64  GPR write enable, address, value.
REQ-009 SHALL have port in_stall  output  1  batch not accepted this cycle (drop_mode=0 only).
REQ-010 SHALL have port out_valid / out_ready  output / input  1 / 1  record drain handshake.
REQ-011 SHALL have port out_rec  output  cmt_rec_t  head record {seq[63:0], lost, pc, ir, gprw, gpra, gprv}.
REQ-012 SHALL have port level  output  $clog2(depth)+1  occupied slots.
REQ-013 SHALL have port drops  output  64  records discarded since reset.

Function
REQ-014 SHALL compute n = popcount(cmt_vld) and free = depth - level, using registered level only (same-cycle pop not credited).
REQ-015 SHALL accept the batch all-or-nothing: accept when n <= free; n = 0 is a no-op.
REQ-016 On accept, SHALL write valid lanes in ascending lane order into consecutive slots from wr_ptr; wr_ptr advances by n modulo depth.
REQ-017 SHALL stamp each accepted record with seq = running count, incremented per record, 64-bit wrap.
REQ-018 drop_mode=0: when n > free, SHALL assert in_stall combinationally in that cycle, write nothing, seq unchanged.
REQ-019 drop_mode=1: in_stall SHALL be 0; when n > free, drops += n, nothing written, and a sticky lost flag set.
REQ-020 SHALL place lost=1 on the first record accepted after any drop, then clear the flag; drops saturates at 2^64-1.
REQ-021 out_valid SHALL equal (level != 0); out_rec SHALL be the slot at rd_ptr, read combinationally.
REQ-022 SHALL pop one record when out_valid & out_ready; rd_ptr advances by 1 modulo depth.
REQ-023 A record accepted in cycle t SHALL first be visible at out_rec in cycle t+1.
REQ-024 Simultaneous push n and pop SHALL update level to level + n - 1.
REQ-025 out_rec SHALL hold stable while out_valid & ~out_ready.
REQ-026 Pointer wrap SHALL be transparent: a batch straddling slot depth-1 SHALL continue at slot 0.

Reset
REQ-027 On rst low, SHALL asynchronously clear wr_ptr, rd_ptr, level, seq, drops and lost; out_valid becomes 0.
REQ-028 Storage array contents SHALL NOT be reset.
REQ-029 Reset mid-operation SHALL discard all buffered records; first post-reset record has seq 0, lost 0.

Structure
REQ-030 cmt_rec_t and record field widths SHALL live in the shared sim package.
REQ-031 Lane compaction (per-lane prefix-sum slot offsets) SHALL be a sub-module cmt_compact, parametrised by lanes.
REQ-032 SHALL contain no assertions that alter behaviour; overflow and underflow immediate assertions are allowed.

Verification
REQ-033 lanes=4, depth=8: cmt_vld=4'b1011 once -> next cycle level=3, out_rec lanes 0,1,3 in order, seq 0,1,2.
REQ-034 depth=8, level=6, mode 0, cmt_vld=4'b0111 -> in_stall=1, level stays 6; draining 1 then re-presenting -> accepted, level 8.
REQ-035 Same fill, mode 1 -> drops=3, in_stall=0; next accepted record has lost=1, the one after lost=0.
REQ-036 wr_ptr=6, depth=8, push 4 with out_ready=1, level=2 -> slots 6,7,0,1 written, level=5.
REQ-037 out_ready held 0 for 5 cycles with level=2 -> out_rec unchanged; level unchanged.
REQ-038 Drive rst low mid-burst with level=5, drops=2 -> level, drops, seq read 0 immediately, out_valid=0.
